// File: rtl/p_addsub_seq.sv
// p_addsub_seq: command/operand sequencer driving one packed add/sub datapath, with multi-precision carry chaining at pw=32.
// Optional abort input is enabled by defining P_ADDSUB_SEQ_ABORT_EN.
module p_addsub (
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [4:0]  pw,
  input  logic        sub,
  input  logic        c_en,
  output logic [31:0] result,
  output logic [31:0] c_out
);
  always_comb begin
    logic k, ci, b;
    k = 1'b0;
    result = '0;
    c_out = '0;
    for (int i = 0; i < 32; i++) begin
      ci = ((pw[0] && i == 0) || (pw[1] && i % 16 == 0) || (pw[2] && i % 8 == 0) ||
            (pw[3] && i % 4 == 0) || (pw[4] && i % 2 == 0)) ? sub : (c_en & k);
      b = rhs[i] ^ sub;
      result[i] = lhs[i] ^ b ^ ci;
      k = (lhs[i] & b) | (ci & (lhs[i] ^ b));
      c_out[i] = k;
    end
  end
endmodule

module p_addsub_seq #(
  parameter int MAX_LEN = 16,
  parameter int LW = $clog2(MAX_LEN)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
`ifdef P_ADDSUB_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_pw,
  input  logic          cmd_sub,
  input  logic [LW-1:0] cmd_len,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [31:0]   op_lhs,
  input  logic [31:0]   op_rhs,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic          res_last,
  output logic          res_carry
);
  typedef enum logic [1:0] {IDLE, WAIT_OP, PASS2, OUT} state_t;
  state_t state, state_nx;
  logic [4:0] pw;
  logic sub, c1, cf, fix, ab, dp_c31;
  logic [LW-1:0] len, cnt;
  logic [31:0] r, dp_res;
  logic [30:0] lane_c_unused;
`ifdef P_ADDSUB_SEQ_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  assign cmd_ready = state == IDLE;
  assign op_ready = state == WAIT_OP;
  assign res_valid = state == OUT;
  assign res_data = res_valid ? r : '0;
  assign res_carry = res_valid & cf;
  assign res_last = res_valid & (cnt == len);
  // a second +1/-1 pass folds in the incoming carry/borrow for multi-precision words
  assign fix = pw[0] & (sub ? ~cf : cf);
  p_addsub u_dp (
    .lhs(state == PASS2 ? r : op_lhs),
    .rhs(state == PASS2 ? 32'd1 : op_rhs),
    .pw(state == PASS2 ? 5'b00001 : pw),
    .sub(sub),
    .c_en(1'b1),
    .result(dp_res),
    .c_out({dp_c31, lane_c_unused})
  );
  always_comb
    state_nx = ab ? IDLE :
               state == IDLE    ? (cmd_valid ? WAIT_OP : IDLE) :
               state == WAIT_OP ? (op_valid ? (fix ? PASS2 : OUT) : WAIT_OP) :
               state == PASS2   ? OUT :
               (res_ready ? (res_last ? IDLE : WAIT_OP) : OUT);
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      pw <= 5'b00001;
      sub <= 1'b0;
      len <= '0;
      cnt <= '0;
      r <= '0;
      c1 <= 1'b0;
      cf <= 1'b0;
    end else if (ab) begin
      cf <= 1'b0;
    end else begin
      if (cmd_ready && cmd_valid) begin
        pw <= $onehot(cmd_pw) ? cmd_pw : 5'b00001;
        sub <= cmd_sub;
        len <= cmd_len;
        cnt <= '0;
        cf <= cmd_sub;
      end
      if (op_ready && op_valid) begin
        r <= dp_res;
        c1 <= dp_c31;
        if (!fix) cf <= pw[0] & dp_c31;
      end
      if (state == PASS2) begin
        r <= dp_res;
        cf <= sub ? (c1 & dp_c31) : (c1 | dp_c31);
      end
      if (res_valid && res_ready && !res_last) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_p_addsub_seq.sv
// tb_p_addsub_seq: randomized scoreboard bench for p_addsub_seq against a word-level arithmetic model.
module tb_p_addsub_seq;
  typedef struct {
    logic [31:0] d;
    logic c;
    logic l;
    int lat;
  } exp_t;
  logic g_clk = 1'b0, g_resetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_sub = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
  logic [4:0] cmd_pw = '0;
  logic [3:0] cmd_len = '0;
  logic [31:0] op_lhs = '0, op_rhs = '0;
  logic cmd_ready, op_ready, res_valid, res_last, res_carry;
  logic [31:0] res_data;
  exp_t exp_q[$];
  time top_q[$];
  exp_t held;
  time t_op;
  bit seen = 1'b0, rr;
  int checks = 0, errors = 0, hold_n = 0, stall_left = 0;
  logic [31:0] la[16], lb[16];

  p_addsub_seq dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
`ifdef P_ADDSUB_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pw(cmd_pw),
    .cmd_sub(cmd_sub),
    .cmd_len(cmd_len),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_lhs(op_lhs),
    .op_rhs(op_rhs),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_last(res_last),
    .res_carry(res_carry)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: pops the scoreboard on each new result, then checks hold stability under stalls
  always @(negedge g_clk) begin
    if (g_resetn && res_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h want none", res_data);
          held.d = res_data;
          held.c = res_carry;
          held.l = res_last;
        end else begin
          held = exp_q.pop_front();
          t_op = top_q.pop_front();
          chk("data", res_data, held.d);
          chk("carry", 32'(res_carry), 32'(held.c));
          chk("last", 32'(res_last), 32'(held.l));
          chk("latency", 32'(($time - t_op + 5) / 10), 32'(held.lat));
        end
        seen = 1'b1;
        if (hold_n > 0) begin
          stall_left = hold_n;
          hold_n = 0;
        end
      end else begin
        chk("hold_data", res_data, held.d);
        chk("hold_carry", 32'(res_carry), 32'(held.c));
        chk("hold_last", 32'(res_last), 32'(held.l));
      end
      chk("op_ready_in_out", 32'(op_ready), 32'd0);
      chk("cmd_ready_in_out", 32'(cmd_ready), 32'd0);
      if (stall_left > 0) begin
        rr = 1'b0;
        stall_left--;
      end else rr = $urandom_range(0, 3) != 0;
      res_ready = rr;
      if (rr) seen = 1'b0;
    end else begin
      seen = 1'b0;
      res_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic exp_t model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                                 inout bit cf, input bit last);
    exp_t e;
    longint d;
    longint unsigned m, av, bv, r;
    if (w == 32) begin
      e.lat = (s ? !cf : cf) ? 2 : 1;
      d = s ? longint'(a) - longint'(b) - (cf ? 0 : 1) : longint'(a) + longint'(b) + (cf ? 1 : 0);
      e.d = d[31:0];
      cf = s ? (d >= 0) : (d >= 64'sh1_0000_0000);
      e.c = cf;
    end else begin
      m = (64'd1 << w) - 1;
      r = 0;
      for (int l = 0; l < 32 / w; l++) begin
        av = (longint'(a) >> (l * w)) & m;
        bv = (longint'(b) >> (l * w)) & m;
        r |= ((s ? av - bv : av + bv) & m) << (l * w);
      end
      e.d = r[31:0];
      e.c = 1'b0;
      e.lat = 1;
      cf = 1'b0;
    end
    e.l = last;
    return e;
  endfunction

  task automatic send_cmd(input logic [4:0] pw, input logic s, input logic [3:0] len);
    int n = 0;
    @(negedge g_clk);
    cmd_valid = 1'b1;
    cmd_pw = pw;
    cmd_sub = s;
    cmd_len = len;
    while (!cmd_ready && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: cmd_ready 0 want 1");
    end
    @(posedge g_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_op(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge g_clk);
    op_valid = 1'b1;
    op_lhs = a;
    op_rhs = b;
    while (!op_ready && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: op_ready 0 want 1");
    end
    @(posedge g_clk);
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    wait_op(a, b);
    exp_q.push_back(e);
    top_q.push_back($time);
    #1 op_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [4:0] pw, input bit s, input int len);
    bit cf;
    int w;
    exp_t e;
    cf = s;
    w = ($countones(pw) != 1 || pw[0]) ? 32 : pw[1] ? 16 : pw[2] ? 8 : pw[3] ? 4 : 2;
    send_cmd(pw, s, 4'(len));
    for (int i = 0; i <= len; i++) begin
      e = model(w, s, la[i], lb[i], cf, i == len);
      send_op(la[i], lb[i], e);
    end
  endtask

  function automatic logic [31:0] rnd();
    int k = $urandom_range(0, 3);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : $urandom;
  endfunction

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 500) begin
      @(negedge g_clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending want 0", exp_q.size());
    end
  endtask

  initial begin
    logic [4:0] pw;
    exp_t e;
    bit cf;
    #12;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_last", 32'(res_last), 32'd0);
    chk("rst_res_carry", 32'(res_carry), 32'd0);
    // directed vectors
    la[0] = 32'hFFFF_FFFF; lb[0] = 32'h1;
    run_cmd(5'b00001, 1'b0, 0);
    la[0] = 32'hFFFF_FFFF; la[1] = 32'h1; lb[0] = 32'h1; lb[1] = 32'h2;
    run_cmd(5'b00001, 1'b0, 1);
    la[0] = 32'h0; la[1] = 32'h5; lb[0] = 32'h1; lb[1] = 32'h2;
    run_cmd(5'b00001, 1'b1, 1);
    la[0] = 32'h01FF_7F80; la[1] = 32'h0000_00FF; lb[0] = 32'h0101_0101; lb[1] = 32'h1;
    run_cmd(5'b00100, 1'b0, 1);
    drain();
    hold_n = 5;
    la[0] = 32'h8000_0000; lb[0] = 32'h8000_0001;
    run_cmd(5'b00001, 1'b0, 0);
    drain();
    for (int c = 0; c < 30; c++) begin
      int k = $urandom_range(0, 9);
      pw = k < 5 ? 5'b00001 : k < 9 ? 5'(1 << (k - 4)) : ($urandom_range(0, 1) ? 5'b00000 : 5'b10110);
      for (int i = 0; i < 16; i++) begin
        la[i] = rnd();
        lb[i] = rnd();
      end
      run_cmd(pw, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    end
    drain();
    // reset while the second word sits in the correction pass
    la[0] = 32'hFFFF_FFFF; lb[0] = 32'h1;
    cf = 1'b0;
    send_cmd(5'b00001, 1'b0, 4'd1);
    e = model(32, 1'b0, la[0], lb[0], cf, 1'b0);
    send_op(la[0], lb[0], e);
    wait_op(32'h1, 32'h2);
    #1;
    op_valid = 1'b0;
    chk("pass2_res_valid", 32'(res_valid), 32'd0);
    chk("pass2_op_ready", 32'(op_ready), 32'd0);
    chk("pass2_cmd_ready", 32'(cmd_ready), 32'd0);
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_async_res_valid", 32'(res_valid), 32'd0);
    chk("rst_async_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    chk("post_rst_res_carry", 32'(res_carry), 32'd0);
    chk("post_rst_pending", 32'(exp_q.size()), 32'd0);
    la[0] = 32'd2; lb[0] = 32'd3;
    run_cmd(5'b00001, 1'b0, 0);
    drain();
    repeat (3) @(negedge g_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/p_addsub_seq.md
Name: p_addsub_seq

Overview:
- Sequencer for the packed add/sub datapath.
- Accepts a command (pack width, add/sub, word count) and then a stream of 32-bit operand pairs; emits one result word per operand pair.
- At pack width 32 it chains the carry/borrow across words (least-significant word first) to give multi-precision add/sub. It does this by reusing one p_addsub instance for a second correction pass.
- Sits between the crypto instruction issue logic and a single shared p_addsub instance.

Parameters:
- MAX_LEN, 16, maximum words per command.
- LW, 4, width of cmd_len; equals clog2(MAX_LEN).

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; high only in IDLE.
- cmd_pw  in  5  one-hot pack width: [0]=32, [1]=16, [2]=8, [3]=4, [4]=2.
- cmd_sub  in  1  1=subtract, 0=add.
- cmd_len  in  LW  number of words minus 1.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand accept; high only in WAIT_OP.
- op_lhs  in  32  left operand word.
- op_rhs  in  32  right operand word.
- res_valid  out  1  result word valid; high only in OUT.
- res_ready  in  1  result consumer ready.
- res_data  out  32  result word.
- res_last  out  1  final word of the command.
- res_carry  out  1  running carry flag; meaningful with res_last.

Behaviour:
- Reset values:
  - state=IDLE; cmd_ready=1 once reset releases.
  - op_ready=0, res_valid=0, res_data=0, res_last=0, res_carry=0.
  - Word counter=0; cf=0.
- Handshakes:
  - A transfer occurs on any rising edge where valid&&ready.
  - Producers must hold inputs stable while valid&&!ready.
- State IDLE:
  - On command transfer, latch pw, sub and len; cnt=0.
  - Initialise cf: 1 if sub, else 0. Go to WAIT_OP.
  - A cmd_pw that is not one-hot is latched as pw=32.
- State WAIT_OP:
  - Datapath inputs: lhs=op_lhs, rhs=op_rhs, latched pw, sub=latched sub, c_en=1.
  - On operand transfer: r<=result, c1<=c_out[31].
  - Correction is needed only when pw=32 and (add&&cf) or (sub&&!cf). If needed, go to PASS2.
  - Otherwise go to OUT, updating cf<=c1 at pw=32 and cf<=0 for packed widths.
- State PASS2 (exactly one cycle, no handshake):
  - Datapath inputs: lhs=r, rhs=1, pw=32, sub=latched sub, c_en=1.
  - r<=result.
  - Add: cf<=c1|c_out[31]. Sub: cf<=c1&c_out[31].
  - Go to OUT.
- Carry flag meaning: for add, cf is the carry out. For sub, cf is "no borrow", so 1 means lhs>=rhs+borrow_in.
- State OUT:
  - res_valid=1, res_data=r, res_carry=cf, res_last=(cnt==len).
  - On result transfer:
    - If last, go to IDLE.
    - Else cnt<=cnt+1 and go to WAIT_OP.
- Outputs stay stable while res_valid&&!res_ready.
- Latency:
  - Operand transfer to res_valid is 1 cycle without correction, 2 cycles with correction.
  - Max throughput is one word per 2 cycles, because op_ready is low in OUT.
- Packed widths (16/8/4/2): each word is independent, single pass, res_carry=0.
- cmd_len=0 gives a single word, and res_last is high on it.
- cnt never wraps, because it stops at len.
- Reset mid-operation (any state, including PASS2):
  - All state and outputs return to reset values asynchronously.
  - The in-flight command is discarded.
- Unused c_out bits of the datapath are ignored.

Optional Feature:
- Macro P_ADDSUB_SEQ_ABORT_EN adds input port abort (1 bit).
- With the macro: abort=1 at any clock edge forces state<=IDLE, res_valid<=0 and cf<=0, discarding pending results. Abort takes priority over all transfers in that cycle.
- Without the macro: the port is absent and commands always run to completion.

Test Plan:
- Add, pw=32, len=0: 0xFFFFFFFF+0x00000001 → res_data=0x00000000, res_carry=1, res_last=1; res_valid 1 cycle after operand transfer.
- Add, pw=32, len=1:
  - Input: lhs {0xFFFFFFFF, 0x00000001}, rhs {0x00000001, 0x00000002}.
  - Expected: {0x00000000, 0x00000004}.
  - Word 1 passes through PASS2 (res_valid 2 cycles after transfer); final res_carry=0.
- Sub, pw=32, len=1:
  - Input: lhs {0x00000000, 0x00000005}, rhs {0x00000001, 0x00000002}.
  - Expected: {0xFFFFFFFF, 0x00000002}; res_carry=0 on word 0 and 1 on word 1 (last).
- Packed add, pw_8, len=1:
  - Word 0: 0x01FF7F80+0x01010101 → 0x02008081.
  - Word 1: 0x000000FF+0x00000001 → 0x00000000.
  - res_carry=0 on both; no PASS2 entered.
- Backpressure: hold res_ready=0 for 5 cycles in OUT → res_data, res_last and res_carry unchanged; op_ready=0 and cmd_ready=0 throughout.
- Reset in PASS2: drop g_resetn → res_valid=0 immediately. After release, cmd_ready=1 and a new len=0 add of 2+3 returns 5.
